// File: rtl/uart_rx_deframer.sv
// ----------------------------------------------------------------------------
// uart_rx_deframer
//
// UART receive front end. Synchronizes the asynchronous RX pin, recovers 8N1
// frames by counting clk cycles from the start-bit edge, and presents each
// received byte on a ready/valid interface. Framing errors and overruns are
// reported as single-cycle pulses.
//
// Parameters:
//   CLOCK_FREQ  clk frequency in Hz
//   BAUD_RATE   line rate in bit/s
//
// Ports:
//   clk             system clock
//   rst             synchronous, active-high reset
//   serial_in       asynchronous RX line, idle high
//   data_out        received byte (stable while data_out_valid is high)
//   data_out_valid  byte available
//   data_out_ready  consumer accepts byte (transfer on clk edge with valid)
//   framing_error   one-cycle pulse: stop bit sampled low
//   overrun         one-cycle pulse: completed byte dropped, no storage free
//
// Build option:
//   UART_RX_FIFO_EN  when defined, a 4-entry FIFO replaces the single
//                    holding register.
// ----------------------------------------------------------------------------
module uart_rx_deframer #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    output logic       framing_error,
    output logic       overrun
);

    localparam int SYMBOL_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int SAMPLE_TIME = SYMBOL_TIME / 2;
    localparam int CNT_W       = $clog2(SYMBOL_TIME) + 1;

    localparam logic [CNT_W-1:0] SYM_LAST = CNT_W'(SYMBOL_TIME - 1);
    localparam logic [CNT_W-1:0] SMP_LAST = CNT_W'(SAMPLE_TIME - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizer; both flops reset to the idle line level.
    // ------------------------------------------------------------------
    logic sync1_q;
    logic rx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rx_q    <= 1'b1;
        end else begin
            sync1_q <= serial_in;
            rx_q    <= sync1_q;
        end
    end

    // ------------------------------------------------------------------
    // Frame recovery FSM
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       byte_q, byte_d;
    logic             ferr_q, ferr_d;
    logic             push;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            byte_q  <= '0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            byte_q  <= byte_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        byte_d  = byte_q;
        ferr_d  = 1'b0;
        push    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!rx_q) begin
                    cnt_d   = '0;
                    state_d = S_START;
                end
            end

            S_START: begin
                if (cnt_q == SMP_LAST) begin
                    if (rx_q) begin
                        // Start bit gone by mid-bit: treat as a glitch.
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = S_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_DATA: begin
                if (cnt_q == SYM_LAST) begin
                    cnt_d         = '0;
                    byte_d[idx_q] = rx_q;
                    idx_d         = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_STOP: begin
                if (cnt_q == SYM_LAST) begin
                    if (rx_q) begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_WAIT_IDLE: begin
                // Hold off while the line is low so a break is not
                // mistaken for a stream of start bits.
                if (rx_q) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output storage
    // ------------------------------------------------------------------
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       ovr_q, ovr_d;
    logic       pop;

`ifdef UART_RX_FIFO_EN
    logic [7:0] mem_q [4];
    logic [2:0] wr_q, wr_d;
    logic [2:0] rd_q, rd_d;
    logic       full;
    logic       do_push;
    logic [7:0] head;

    // valid_q always equals "FIFO not empty", and data_q is a registered
    // copy of the entry at the read pointer. When the FIFO is about to be
    // empty except for the byte being written this cycle, the head is
    // forwarded from the incoming byte instead of the (not yet written) RAM.
    always_comb begin
        pop     = valid_q && data_out_ready;
        full    = (wr_q[2] != rd_q[2]) && (wr_q[1:0] == rd_q[1:0]);
        do_push = push && (!full || pop);
        ovr_d   = push && full && !pop;
        wr_d    = wr_q + {2'b00, do_push};
        rd_d    = rd_q + {2'b00, pop};
        valid_d = (rd_d != wr_d);
        if (do_push && (rd_d == wr_q)) begin
            head = byte_q;
        end else begin
            head = mem_q[rd_d[1:0]];
        end
        data_d = valid_d ? head : data_q;
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q[1:0]] <= byte_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end
`else
    always_comb begin
        pop     = valid_q && data_out_ready;
        ovr_d   = push && valid_q && !data_out_ready;
        data_d  = data_q;
        valid_d = valid_q;
        if (push && (!valid_q || data_out_ready)) begin
            // Covers the simultaneous consume-and-load case: valid stays 1.
            data_d  = byte_q;
            valid_d = 1'b1;
        end else if (pop) begin
            valid_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_out       = data_q;
    assign data_out_valid = valid_q;
    assign framing_error  = ferr_q;
    assign overrun        = ovr_q;

endmodule
